// File: rtl/csa_bist_ctrl.sv
// Self-test and reconfiguration controller for the 7-bit reconfigurable carry-select adder.
// Latency: 34 cycles from start to done; start is ignored while a run is in progress.
module csa_bist_ctrl #(
  parameter int NPAT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] test_output,
  output logic        test,
  output logic [3:0]  test_data,
  output logic [2:0]  is,
  output logic [3:0]  ss,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        multi_fault,
  output logic [1:0]  fault_idx,
  output logic [3:0]  fail_map
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] APPLY  = 3'd1;
  localparam logic [2:0] CHECK  = 3'd2;
  localparam logic [2:0] DECIDE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [3:0] LAST_PAT = 4'(NPAT - 1);

  logic [2:0] state;
  logic [3:0] p;
  logic [3:0] acc;
  logic [5:0] gold;
  logic [3:0] miss;
  logic       one_hot;
  logic [1:0] hot_idx;

  // Expected response of a healthy cell for the pattern currently broadcast.
  always_comb begin
    logic a, b, n0, n1;
    a  = p[1] ^ p[0];
    b  = p[3] ^ p[2];
    n0 = ~(p[1] | p[0]);
    n1 = ~(p[3] | p[2]);
    gold = {a ? b : n1, n0 ? b : n1, a ? ~b : b, n0 ? ~b : b, ~a, a};
  end

  always_comb begin
    miss = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      miss[k] = (test_output[6*k +: 6] != gold);
    end
  end

  always_comb begin
    one_hot = (acc != 4'b0000) && ((acc & (acc - 4'd1)) == 4'b0000);
    hot_idx = 2'd0;
    case (acc)
      4'b0010: hot_idx = 2'd1;
      4'b0100: hot_idx = 2'd2;
      4'b1000: hot_idx = 2'd3;
      default: hot_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      p           <= 4'd0;
      acc         <= 4'd0;
      test        <= 1'b0;
      test_data   <= 4'd0;
      is          <= 3'b000;
      ss          <= 4'b0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      multi_fault <= 1'b0;
      fault_idx   <= 2'd0;
      fail_map    <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= APPLY;
            p         <= 4'd0;
            acc       <= 4'd0;
            test      <= 1'b1;
            test_data <= 4'd0;
            busy      <= 1'b1;
          end
        end
        APPLY: state <= CHECK;
        CHECK: begin
          acc <= acc | miss;
          if (p == LAST_PAT) begin
            state <= DECIDE;
            test  <= 1'b0;
          end else begin
            p         <= p + 4'd1;
            test_data <= p + 4'd1;
            state     <= APPLY;
          end
        end
        DECIDE: begin
          fail_map <= acc;
          // Only a single bad cell can be steered onto the spare; otherwise stay in normal routing.
          if (one_hot) begin
            is          <= 3'b111 << hot_idx;
            ss          <= 4'b1111 << hot_idx;
            fault       <= 1'b1;
            multi_fault <= 1'b0;
            fault_idx   <= hot_idx;
          end else begin
            is          <= 3'b000;
            ss          <= 4'b0000;
            fault       <= 1'b0;
            multi_fault <= (acc != 4'b0000);
            fault_idx   <= 2'd0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_bist_ctrl.sv
// Directed bench for csa_bist_ctrl with a behavioural adder model and fault injection.
module tb_csa_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] test_output;
  logic        test;
  logic [3:0]  test_data;
  logic [2:0]  is;
  logic [3:0]  ss;
  logic        busy;
  logic        done;
  logic        fault;
  logic        multi_fault;
  logic [1:0]  fault_idx;
  logic [3:0]  fail_map;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] sa0_mask = 24'h0;
  logic [23:0] p0_flip  = 24'h0;

  always #5 clk = ~clk;

  csa_bist_ctrl #(.NPAT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .test_output(test_output),
    .test(test), .test_data(test_data), .is(is), .ss(ss), .busy(busy),
    .done(done), .fault(fault), .multi_fault(multi_fault),
    .fault_idx(fault_idx), .fail_map(fail_map)
  );

  // Hand-tabulated healthy cell response per pattern.
  function automatic logic [5:0] cell_ref(input logic [3:0] p);
    case (p)
      4'd0:  return 6'h26;
      4'd1:  return 6'h19;
      4'd2:  return 6'h19;
      4'd3:  return 6'h32;
      4'd4:  return 6'h1A;
      4'd5:  return 6'h25;
      4'd6:  return 6'h25;
      4'd7:  return 6'h0E;
      4'd8:  return 6'h1A;
      4'd9:  return 6'h25;
      4'd10: return 6'h25;
      4'd11: return 6'h0E;
      4'd12: return 6'h06;
      4'd13: return 6'h09;
      4'd14: return 6'h09;
      default: return 6'h02;
    endcase
  endfunction

  assign test_output = ({4{cell_ref(test_data)}} & ~sa0_mask)
                     ^ ((test_data == 4'd0) ? p0_flip : 24'h0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run; cycle c below is cycle T+c where start was sampled at edge T.
  task automatic run(input logic [3:0] e_map, input logic [2:0] e_is, input logic [3:0] e_ss,
                     input logic e_fault, input logic e_multi, input logic [1:0] e_idx,
                     input logic spot, input logic poke_start);
    logic [3:0]  old_map;
    logic [2:0]  old_is;
    logic [3:0]  old_ss;
    logic        old_fault;
    logic        old_multi;
    logic [5:0]  spot_exp;
    old_map   = fail_map;
    old_is    = is;
    old_ss    = ss;
    old_fault = fault;
    old_multi = multi_fault;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c > 1) tick();
      start = poke_start && (c == 20 || c == 34);
      chk("busy", busy, (c <= 33));
      chk("test", test, (c <= 32));
      chk("done", done, (c == 34));
      if (c <= 32) chk("test_data", test_data, (c - 1) / 2);
      if (c <= 33) begin
        chk("map_hold", fail_map, old_map);
        chk("is_hold", is, old_is);
        chk("ss_hold", ss, old_ss);
        chk("fault_hold", {old_fault, old_multi} == {fault, multi_fault}, 1'b1);
      end
      if (spot && c <= 32 && (c % 2) == 0) begin
        case ((c - 1) / 2)
          0:  begin spot_exp = 6'h26; chk("gold_p0",  test_output[5:0], spot_exp); end
          5:  begin spot_exp = 6'h25; chk("gold_p5",  test_output[5:0], spot_exp); end
          15: begin spot_exp = 6'h02; chk("gold_p15", test_output[5:0], spot_exp); end
          default: ;
        endcase
      end
      if (c == 34) begin
        chk("fail_map", fail_map, e_map);
        chk("is", is, e_is);
        chk("ss", ss, e_ss);
        chk("fault", fault, e_fault);
        chk("multi_fault", multi_fault, e_multi);
        if (e_fault) chk("fault_idx", fault_idx, e_idx);
      end
    end
    start = 1'b0;
    tick();
    chk("idle_after", {busy, test, done}, 3'b000);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_outs", {test, test_data, is, ss, busy, done, fault, multi_fault, fault_idx, fail_map},
        26'h0);
    tick();

    run(4'b0000, 3'b000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);

    sa0_mask = 24'h000800;
    run(4'b0010, 3'b110, 4'b1110, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    sa0_mask = 24'h0;

    p0_flip = 24'h040000;
    run(4'b1000, 3'b000, 4'b1000, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
    p0_flip = 24'h0;

    sa0_mask = 24'h002002;
    run(4'b0101, 3'b000, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    sa0_mask = 24'h0;

    // Leave a single-fault configuration in place, then reset mid-run.
    sa0_mask = 24'h000800;
    run(4'b0010, 3'b110, 4'b1110, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_outs", {test, test_data, is, ss, busy, done, fault, multi_fault, fault_idx, fail_map},
        26'h0);
    begin
      int seen_done;
      seen_done = 0;
      for (int c = 0; c < 30; c++) begin
        tick();
        if (done || busy) seen_done++;
      end
      chk("no_done_after_rst", seen_done, 0);
    end
    sa0_mask = 24'h0;

    // Continuous start: done pulses every 35 cycles.
    begin
      int first_done;
      int second_done;
      first_done  = -1;
      second_done = -1;
      start = 1'b1;
      tick();
      for (int c = 1; c <= 75; c++) begin
        if (c > 1) tick();
        if (done) begin
          if (first_done < 0) first_done = c;
          else if (second_done < 0) second_done = c;
        end
      end
      start = 1'b0;
      chk("cont_first_done", first_done, 34);
      chk("cont_second_done", second_done, 69);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
